// File: rtl/hilo_mdu_ctrl.sv
// hilo_mdu_ctrl: sequences multi-cycle ALU multiply/divide and owns the HI/LO pair.
// Operands are registered into the ALU and held for a fixed number of cycles.
// Result/Result2 are then captured into LO/HI. MTHI/MTLO write HI/LO directly from IDLE.
module hilo_mdu_ctrl #(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             abort,
    output logic [WIDTH-1:0] alu_x,
    output logic [WIDTH-1:0] alu_y,
    output logic [3:0]       alu_s,
    input  logic [WIDTH-1:0] alu_result,
    input  logic [WIDTH-1:0] alu_result2,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    // One extra value of headroom keeps the width >= 1 even when both counts are 1.
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [1:0] OP_MUL  = 2'b00;
    localparam logic [1:0] OP_DIV  = 2'b01;
    localparam logic [1:0] OP_MTHI = 2'b10;
    localparam logic [1:0] OP_MTLO = 2'b11;

    localparam logic [3:0] ALU_S_MUL = 4'd3;
    localparam logic [3:0] ALU_S_DIV = 4'd4;

    localparam logic [CNT_W-1:0] MUL_CNT_INIT = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_CNT_INIT = CNT_W'(DIV_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             dz_q;
    logic [WIDTH-1:0] alu_x_q;
    logic [WIDTH-1:0] alu_y_q;
    logic [3:0]       alu_s_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;

    // Sequencer: accepts requests in IDLE, counts the hold time in RUN, pulses DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            dz_q    <= 1'b0;
            alu_x_q <= '0;
            alu_y_q <= '0;
            alu_s_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else if (abort) begin
            // Flush wins over everything, including a same-cycle start in IDLE.
            state_q <= ST_IDLE;
            dz_q    <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        unique case (op)
                            OP_MUL: begin
                                alu_x_q <= rs_val;
                                alu_y_q <= rt_val;
                                alu_s_q <= ALU_S_MUL;
                                cnt_q   <= MUL_CNT_INIT;
                                state_q <= ST_RUN;
                            end
                            OP_DIV: begin
                                if (rt_val == '0) begin
                                    // Divide by zero: skip the ALU, report straight away.
                                    dz_q    <= 1'b1;
                                    state_q <= ST_DONE;
                                end else begin
                                    alu_x_q <= rs_val;
                                    alu_y_q <= rt_val;
                                    alu_s_q <= ALU_S_DIV;
                                    cnt_q   <= DIV_CNT_INIT;
                                    state_q <= ST_RUN;
                                end
                            end
                            OP_MTHI: hi_q <= rs_val;
                            OP_MTLO: lo_q <= rs_val;
                            default: ;
                        endcase
                    end
                end
                ST_RUN: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        lo_q    <= alu_result;
                        hi_q    <= alu_result2;
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    dz_q    <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Status decoded purely from registered state, so it is glitch-free.
    assign busy        = (state_q != ST_IDLE);
    assign done        = (state_q == ST_DONE);
    assign div_by_zero = (state_q == ST_DONE) && dz_q;

    assign alu_x = alu_x_q;
    assign alu_y = alu_y_q;
    assign alu_s = alu_s_q;
    assign hi    = hi_q;
    assign lo    = lo_q;

endmodule
